// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory family.
//   READ_*  : output path selection (bypass or registered pipeline stage)
//   WRITE_* : what the first output stage shows during a write cycle
package mem_pkg;

    localparam int unsigned READ_BYPASS      = 0;
    localparam int unsigned READ_PIPELINE    = 1;

    localparam int unsigned WRITE_NORMAL     = 0;
    localparam int unsigned WRITE_THROUGH    = 1;
    localparam int unsigned WRITE_READ_FIRST = 2;

endpackage

// File: rtl/mem_eeprom_if.sv
// mem_eeprom_if: single-port memory access bus (no handshake, one access per cycle).
//   ce   : clock enable for the array and the first output stage
//   oce  : output-register enable (pipeline read mode only)
//   wre  : 1 = write, 0 = read
//   ad   : word address
//   din  : write data
//   dout : read data
interface mem_eeprom_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 1
);
    logic              ce;
    logic              oce;
    logic              wre;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output ce, oce, wre, ad, din, input dout);
    modport slave  (input ce, oce, wre, ad, din, output dout);
endinterface

// File: rtl/mem_eeprom_oreg.sv
// mem_eeprom_oreg: optional second output stage.
//   clk, reset : clock and synchronous active-high reset
//   oce        : load enable for the stage register
//   d          : stage-1 data in
//   q          : stage-2 data in pipeline mode, stage-1 pass-through in bypass mode
module mem_eeprom_oreg
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned READ_MODE = READ_BYPASS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              oce,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_stage2 = '0;

    // Stage-2 register; reset wins over oce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage2 <= '0;
        end else if (oce) begin
            r_stage2 <= d;
        end
    end

    // In bypass mode the register is left unloaded and is trimmed away.
    assign q = (READ_MODE == READ_PIPELINE) ? r_stage2 : d;

endmodule

// File: rtl/mem_eeprom.sv
// mem_eeprom: single-port 2**ADDR_W x DATA_W RAM with registered read port.
//   clk   : clock, all logic on the rising edge
//   reset : synchronous active-high; clears the output stages, never the array
//   bus   : mem_eeprom_if slave (ce, oce, wre, ad, din -> dout)
module mem_eeprom
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned READ_MODE  = READ_BYPASS,
    parameter int unsigned WRITE_MODE = WRITE_READ_FIRST
) (
    input  logic         clk,
    input  logic         reset,
    mem_eeprom_if.slave  bus
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    // Array carries no reset so it maps onto block RAM; zero power-up image.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] r_stage1 = '0;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_stage1_nxt;
    logic [DATA_W-1:0] w_dout;

    // A write coinciding with reset is dropped.
    assign w_wr_en   = bus.ce & bus.wre & ~reset;
    assign w_rd_word = r_mem[bus.ad];

    // Array write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[bus.ad] <= bus.din;
        end
    end

    // Stage-1 source: array on reads, write-mode dependent on writes.
    always_comb begin
        w_stage1_nxt = r_stage1;
        if (bus.ce) begin
            if (!bus.wre) begin
                w_stage1_nxt = w_rd_word;
            end else begin
                case (WRITE_MODE)
                    WRITE_THROUGH:    w_stage1_nxt = bus.din;
                    WRITE_READ_FIRST: w_stage1_nxt = w_rd_word;
                    default:          w_stage1_nxt = r_stage1;
                endcase
            end
        end
    end

    // Stage-1 register; reset wins over ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage1 <= '0;
        end else begin
            r_stage1 <= w_stage1_nxt;
        end
    end

    mem_eeprom_oreg #(
        .DATA_W    (DATA_W),
        .READ_MODE (READ_MODE)
    ) u_oreg (
        .clk   (clk),
        .reset (reset),
        .oce   (bus.oce),
        .d     (r_stage1),
        .q     (w_dout)
    );

    assign bus.dout = w_dout;

endmodule

// File: tb/tb_mem_eeprom.sv
// tb_mem_eeprom: five mem_eeprom configurations driven by one shared stimulus
// stream and checked every cycle against a behavioural model, plus directed
// checks on the default configuration.
module tb_mem_eeprom;
    import mem_pkg::*;

    localparam int unsigned N_CFG = 5;
    // cfg0 = defaults, cfg1 = normal write, cfg2 = write-through,
    // cfg3 = pipeline + read-first, cfg4 = pipeline + write-through
    localparam int unsigned RM [N_CFG] = '{0, 0, 0, 1, 1};
    localparam int unsigned WM [N_CFG] = '{2, 0, 1, 2, 1};

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              ce    = 1'b0;
    logic              oce   = 1'b1;
    logic              wre   = 1'b0;
    logic [15:0]       ad    = '0;
    logic              din   = 1'b0;
    logic [N_CFG-1:0]  dout_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_CFG; g++) begin : g_dut
        mem_eeprom_if #(.ADDR_W(16), .DATA_W(1)) bus ();
        assign bus.ce    = ce;
        assign bus.oce   = oce;
        assign bus.wre   = wre;
        assign bus.ad    = ad;
        assign bus.din   = din;
        assign dout_v[g] = bus.dout;

        mem_eeprom #(
            .ADDR_W     (16),
            .DATA_W     (1),
            .READ_MODE  (RM[g]),
            .WRITE_MODE (WM[g])
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    // Behavioural model: word array plus the two visible output stages.
    bit m_mem [65536];
    bit m_s1  [N_CFG];
    bit m_s2  [N_CFG];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_dout(input int i);
        return (RM[i] == READ_PIPELINE) ? m_s2[i] : m_s1[i];
    endfunction

    // Advance one edge, update the model from the applied inputs, compare all.
    task automatic step();
        bit rd;
        bit n1;
        bit n2;
        @(posedge clk);
        rd = m_mem[ad];
        for (int i = 0; i < N_CFG; i++) begin
            n2 = reset ? 1'b0 : (oce ? m_s1[i] : m_s2[i]);
            if (reset)     n1 = 1'b0;
            else if (!ce)  n1 = m_s1[i];
            else if (!wre) n1 = rd;
            else begin
                case (WM[i])
                    WRITE_THROUGH:    n1 = din;
                    WRITE_READ_FIRST: n1 = rd;
                    default:          n1 = m_s1[i];
                endcase
            end
            m_s1[i] = n1;
            m_s2[i] = n2;
        end
        if (ce && wre && !reset) m_mem[ad] = din;
        #1;
        for (int i = 0; i < N_CFG; i++) begin
            check($sformatf("model_cfg%0d", i), 32'(dout_v[i]), 32'(model_dout(i)));
        end
    endtask

    task automatic access(input bit c, input bit w, input logic [15:0] a, input bit d,
                          input bit o = 1'b1, input bit r = 1'b0);
        ce = c; wre = w; ad = a; din = d; oce = o; reset = r;
        step();
    endtask

    task automatic wr(input logic [15:0] a, input bit d);
        access(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [15:0] a);
        access(1'b1, 1'b0, a, 1'b0);
    endtask

    initial begin
        #1;
        check("powerup_dout", 32'(dout_v), 0);

        // Reset sequence.
        access(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        access(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        check("reset_dout", 32'(dout_v), 0);

        // Corner addresses.
        wr(16'h0000, 1'b1);
        wr(16'hFFFF, 1'b1);
        wr(16'h0001, 1'b0);
        rd(16'h0000); check("rd_0000", 32'(dout_v[0]), 1);
        rd(16'hFFFF); check("rd_ffff", 32'(dout_v[0]), 1);
        rd(16'h0001); check("rd_0001", 32'(dout_v[0]), 0);

        // Write-mode behaviour on an overwrite.
        wr(16'h1234, 1'b0);
        rd(16'h1234); check("rd_1234_0", 32'(dout_v[0]), 0);
        rd(16'h0000);
        wr(16'h1234, 1'b1);
        check("rbw_old_word",  32'(dout_v[0]), 0);
        check("normal_holds",  32'(dout_v[1]), 1);
        check("through_din",   32'(dout_v[2]), 1);
        rd(16'h1234); check("rd_1234_1", 32'(dout_v[0]), 1);

        // ce=0 freezes output and array.
        rd(16'h0000);
        for (int k = 0; k < 8; k++) begin
            access(1'b0, 1'b1, (k % 2 == 1) ? 16'hFFFF : 16'h0000, 1'b0);
            check("ce0_hold", 32'(dout_v[0]), 1);
        end
        rd(16'h0000); check("ce0_arr_0000", 32'(dout_v[0]), 1);
        rd(16'hFFFF); check("ce0_arr_ffff", 32'(dout_v[0]), 1);

        // Reset clears output, keeps contents, suppresses the write.
        rd(16'h0000);
        access(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("rst_clear", 32'(dout_v[0]), 0);
        rd(16'h0000); check("rst_retain", 32'(dout_v[0]), 1);

        // Pipeline latency and oce gating (cfg3).
        wr(16'h0100, 1'b1);
        wr(16'h0101, 1'b0);
        rd(16'h0101);
        rd(16'h0101);
        rd(16'h0100); check("pipe_lat1", 32'(dout_v[3]), 0);
        rd(16'h0101); check("pipe_lat2", 32'(dout_v[3]), 1);
        rd(16'h0101); check("pipe_lat3", 32'(dout_v[3]), 0);
        access(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("oce_freeze_a", 32'(dout_v[3]), 0);
        check("bypass_no_oce", 32'(dout_v[0]), 1);
        access(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("oce_freeze_b", 32'(dout_v[3]), 0);
        access(1'b1, 1'b0, 16'h0101, 1'b0, 1'b1);
        check("oce_release", 32'(dout_v[3]), 1);

        // Write-through shows din during writes (cfg2).
        wr(16'h0200, 1'b1); check("wt_din_1", 32'(dout_v[2]), 1);
        wr(16'h0200, 1'b0); check("wt_din_0", 32'(dout_v[2]), 0);

        // Aliasing: fill a block plus every single-bit address, clear 0x8000 only.
        for (int a = 0; a < 4096; a++) wr(16'(a), 1'b1);
        for (int k = 12; k < 16; k++) wr(16'(32'(1) << k), 1'b1);
        wr(16'hFFFF, 1'b1);
        wr(16'h8000, 1'b0);
        for (int a = 0; a < 4096; a++) begin
            rd(16'(a));
            check("alias_low", 32'(dout_v[0]), 1);
        end
        for (int k = 12; k < 16; k++) begin
            rd(16'(32'(1) << k));
            check("alias_bit", 32'(dout_v[0]), (k == 15) ? 0 : 1);
        end
        rd(16'hFFFF); check("alias_ffff", 32'(dout_v[0]), 1);

        // Randomised traffic concentrated on a small address window.
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            access($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_eeprom.md
MEM_EEPROM -- requirements
Module: mem_eeprom

Interface
REQ-001 Parameter ADDR_W, default 16, address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 1, word width in bits.
REQ-003 Parameter READ_MODE, default 0; 0 = bypass (1-cycle read), 1 = pipeline (2-cycle read, oce-gated output register).
REQ-004 Parameter WRITE_MODE, default 2; 0 = normal (dout holds during write), 1 = write-through (dout = din), 2 = read-before-write (dout = old word).
REQ-005 Port clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port reset  input  1  reset; synchronous and active-high.
REQ-007 Port ce  input  1  clock enable for array access and the first output stage.
REQ-008 Port oce  input  1  output-register enable; used only when READ_MODE=1.
REQ-009 Port wre  input  1  write enable; 1 = write, 0 = read.
REQ-010 Port ad  input  ADDR_W  word address.
REQ-011 Port din  input  DATA_W  write data.
REQ-012 Port dout  output  DATA_W  read data.

Function
REQ-013 Storage SHALL be a single-port array of 2**ADDR_W x DATA_W bits (65536 x 1 at defaults), with no address aliasing.
REQ-014 Write: at an edge with ce=1, wre=1 and reset=0, the array SHALL store din at ad.
REQ-015 Read, bypass: at an edge with ce=1, wre=0 and reset=0, the stage-1 register SHALL load array[ad]; dout SHALL equal stage-1 one cycle after the address.
REQ-016 Stage-1 during a write SHALL be selected by WRITE_MODE: mode 0 holds, mode 1 loads din, mode 2 loads the pre-write array[ad].
REQ-017 Pipeline: stage-2 SHALL load stage-1 at an edge with oce=1 and reset=0, and hold otherwise; dout SHALL equal stage-2, giving a 2-cycle latency.
REQ-018 With READ_MODE=0, oce SHALL be ignored.
REQ-019 With ce=0, the array and stage-1 SHALL hold; stage-2 still follows oce.
REQ-020 Back-to-back accesses SHALL be accepted every cycle with no stall and no handshake.
REQ-021 Read and write to the same address in consecutive cycles SHALL return the newly written data on the subsequent read.
REQ-022 Out-of-range X/Z on ad is not required to be handled.
REQ-023 The array SHALL be synthesizable as inferred block RAM, with no per-bit reset logic.

Reset
REQ-024 reset=1 at an edge SHALL clear stage-1 and stage-2 to 0, so dout=0 on the next cycle; reset SHALL take priority over ce and oce.
REQ-025 reset SHALL NOT modify array contents.
REQ-026 A write asserted in the same cycle as reset SHALL be suppressed.
REQ-027 Power-up array contents SHALL be all zeros in simulation and the output registers SHALL power up as 0; software clears or initializes contents itself.

Structure
REQ-028 READ_MODE and WRITE_MODE encodings SHALL be localparams in a shared package mem_pkg.
REQ-029 The array and stage-1 SHALL be inline; one sub-module, mem_eeprom_oreg (optional stage-2 register with oce and reset), is the natural split.
REQ-030 The top level SHALL contain no latches or combinational paths from ad to dout.

Verification
REQ-031 Defaults; write 1 to ad=0x0000 and ad=0xFFFF, 0 to ad=0x0001; read each -> dout 1, 1, 0 one cycle after each address.
REQ-032 Defaults; write 0 at ad=0x1234 and read it (0), then write 1 at ad=0x1234 -> dout shows the old value 0 in the write cycle+1; a subsequent read gives 1.
REQ-033 Defaults; fill all 65536 bits with 1 sequentially, then read all -> every dout=1 and no aliasing; then write 0 only at 0x8000 -> only 0x8000 reads 0.
REQ-034 Set dout=1, then hold ce=0 and toggle ad/wre=1 -> dout stays 1 and the array is unchanged.
REQ-035 With dout=1, assert reset one cycle -> dout=0 next cycle; a re-read returns 1 (contents retained); a write in the reset cycle has no effect.
REQ-036 READ_MODE=1 -> data arrives 2 cycles after the address; oce=0 freezes dout; WRITE_MODE=1 -> dout=din during writes.
